// File: rtl/approx_serial_subtractor.sv
// approx_serial_subtractor
// Bit-serial approximate subtractor, LSB first: Diff = A - B - Bin.
// The lowest APPROX_BITS cells drop the incoming borrow from their borrow-out;
// the cells above them are exact. There is a valid/ready handshake on both sides.

module approx_serial_subtractor #(
    parameter int N           = 8,
    parameter int APPROX_BITS = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic         Bout
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // One flag per bit position: set where the cell uses the approximate borrow
    function automatic logic [N-1:0] approx_mask();
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            if (i < APPROX_BITS) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [N-1:0] APPROX_MASK = approx_mask();

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic          borrow;

    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic bo_bit;

    // Subtractor cell for the bit selected by the counter
    always_comb begin
        a_bit = a_reg[cnt];
        b_bit = b_reg[cnt];
        d_bit = a_bit ^ b_bit ^ borrow;
        if (APPROX_MASK[cnt]) begin
            bo_bit = ~a_bit & b_bit;
        end else begin
            bo_bit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
        end
    end

    // Control FSM, operand capture and result assembly, all with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Diff      <= '0;
            Bout      <= 1'b0;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            borrow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        borrow   <= Bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    Diff[cnt] <= d_bit;
                    borrow    <= bo_bit;
                    if (cnt == CW'(N - 1)) begin
                        Bout      <= bo_bit;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_serial_subtractor.sv
// Testbench for approx_serial_subtractor: an exact instance (APPROX_BITS=0)
// and an approximate instance (APPROX_BITS=3) share the same stimulus.

module tb_approx_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       out_ready;

    logic       in_ready0, out_valid0, bout0;
    logic [7:0] diff0;
    logic       in_ready3, out_valid3, bout3;
    logic [7:0] diff3;

    int total = 0;
    int bad   = 0;

    approx_serial_subtractor #(.N(8), .APPROX_BITS(0)) u_exact (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .A(A), .B(B), .Bin(Bin), .out_valid(out_valid0), .out_ready(out_ready),
        .Diff(diff0), .Bout(bout0)
    );

    approx_serial_subtractor #(.N(8), .APPROX_BITS(3)) u_approx (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .A(A), .B(B), .Bin(Bin), .out_valid(out_valid3), .out_ready(out_ready),
        .Diff(diff3), .Bout(bout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-cell reference: {borrow_out, diff}
    function automatic logic [8:0] cell_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic bin, input int k);
        logic       br;
        logic [7:0] d;
        br = bin;
        for (int i = 0; i < 8; i++) begin
            d[i] = a[i] ^ b[i] ^ br;
            if (i < k) br = ~a[i] & b[i];
            else       br = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        return {br, d};
    endfunction

    // Drive one operation, perturb inputs after acceptance, wait for the result, then consume it
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin, input int stall,
                         output logic [7:0] d0, output logic [7:0] d3,
                         output logic bo0, output logic bo3, output int lat);
        @(negedge clk);
        in_valid = 1'b1; A = a; B = b; Bin = bin; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; A = ~a; B = ~b; Bin = ~bin;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid0) begin
                lat = c;
                break;
            end
        end
        d0 = diff0; d3 = diff3; bo0 = bout0; bo3 = bout3;
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready0); end
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid0); end
        total++; if (diff0 !== 8'h00) begin bad++; $display("FAIL reset_diff got=%h want=00", diff0); end
        total++; if (bout0 !== 1'b0) begin bad++; $display("FAIL reset_bout got=%b want=0", bout0); end
        total++; if ({in_ready3, out_valid3, diff3, bout3} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            bad++; $display("FAIL reset_approx got=%b%b_%h_%b want=10_00_0", in_ready3, out_valid3, diff3, bout3);
        end
        rst = 1'b0;
    endtask

    task automatic test_exact_basic;
        logic [7:0] d0, d3; logic bo0, bo3; int lat;
        do_op(8'h05, 8'h0A, 1'b0, 0, d0, d3, bo0, bo3, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL exact_latency got=%0d want=8", lat); end
        total++; if (d0 !== 8'hFB) begin bad++; $display("FAIL exact_diff got=%h want=FB", d0); end
        total++; if (bo0 !== 1'b1) begin bad++; $display("FAIL exact_bout got=%b want=1", bo0); end
    endtask

    task automatic test_approx_error;
        logic [7:0] d0, d3; logic bo0, bo3; int lat;
        do_op(8'h50, 8'h23, 1'b0, 1, d0, d3, bo0, bo3, lat);
        total++; if (d3 !== 8'h35) begin bad++; $display("FAIL approx_diff got=%h want=35", d3); end
        total++; if (bo3 !== 1'b0) begin bad++; $display("FAIL approx_bout got=%b want=0", bo3); end
        total++; if (d0 !== 8'h2D) begin bad++; $display("FAIL approx_exact_ref got=%h want=2D", d0); end
        total++; if ((int'(d3) - int'(d0)) !== 8) begin
            bad++; $display("FAIL approx_error got=%0d want=8", int'(d3) - int'(d0));
        end
    endtask

    task automatic test_borrow_kill;
        logic [7:0] d0, d3; logic bo0, bo3; int lat;
        do_op(8'h00, 8'h01, 1'b0, 2, d0, d3, bo0, bo3, lat);
        total++; if (d3 !== 8'h03) begin bad++; $display("FAIL kill_diff got=%h want=03", d3); end
        total++; if (bo3 !== 1'b0) begin bad++; $display("FAIL kill_bout got=%b want=0", bo3); end
        total++; if ({bo0, d0} !== 9'h1FF) begin bad++; $display("FAIL kill_exact got=%b_%h want=1_FF", bo0, d0); end
    endtask

    task automatic test_backpressure;
        int lat;
        @(negedge clk);
        in_valid = 1'b1; A = 8'hFF; B = 8'h00; Bin = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid3) begin lat = c; break; end
        end
        total++; if (lat !== 8) begin bad++; $display("FAIL bp_latency got=%0d want=8", lat); end
        in_valid = 1'b1; A = 8'h11; B = 8'h22; Bin = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            total++; if ({out_valid3, diff3, bout3, in_ready3} !== {1'b1, 8'hFE, 1'b0, 1'b0}) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%b_%h_%b_%b want=1_FE_0_0", c, out_valid3, diff3, bout3, in_ready3);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if ({out_valid3, in_ready3, diff3} !== {1'b0, 1'b1, 8'hFE}) begin
            bad++; $display("FAIL bp_release got=%b_%b_%h want=0_1_FE", out_valid3, in_ready3, diff3);
        end
        repeat (3) @(negedge clk);
        total++; if (in_ready3 !== 1'b1) begin bad++; $display("FAIL bp_ignored got=%b want=1", in_ready3); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d0, d3; logic bo0, bo3; int lat; int seen;
        @(negedge clk);
        in_valid = 1'b1; A = 8'h80; B = 8'h01; Bin = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({in_ready0, out_valid0, diff0} !== {1'b1, 1'b0, 8'h00}) begin
            bad++; $display("FAIL midreset_state got=%b_%b_%h want=1_0_00", in_ready0, out_valid0, diff0);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid0 || out_valid3) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midreset_partial got=%0d want=0", seen); end
        do_op(8'h80, 8'h01, 1'b0, 0, d0, d3, bo0, bo3, lat);
        total++; if ({bo0, d0} !== 9'h07F) begin bad++; $display("FAIL midreset_exact got=%b_%h want=0_7F", bo0, d0); end
        total++; if ({bo3, d3} !== 9'h083) begin bad++; $display("FAIL midreset_approx got=%b_%h want=0_83", bo3, d3); end
        total++; if (lat !== 8) begin bad++; $display("FAIL midreset_latency got=%0d want=8", lat); end
    endtask

    task automatic test_back_to_back;
        int first, second;
        first = -1; second = -1;
        @(negedge clk);
        in_valid = 1'b1; A = 8'h05; B = 8'h0A; Bin = 1'b0; out_ready = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid0) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        out_ready = 1'b0;
        total++; if (first !== 9) begin bad++; $display("FAIL b2b_first got=%0d want=9", first); end
        total++; if ((second - first) !== 10) begin bad++; $display("FAIL b2b_period got=%0d want=10", second - first); end
    endtask

    task automatic test_random_sweep;
        logic [7:0] a, b, d0, d3; logic bin, bo0, bo3; int lat;
        logic [8:0] want0, want3;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            bin = 1'($urandom_range(0, 1));
            do_op(a, b, bin, int'($urandom_range(0, 3)), d0, d3, bo0, bo3, lat);
            want0 = {1'b0, a} - {1'b0, b} - {8'h00, bin};
            want3 = cell_model(a, b, bin, 3);
            total++; if ({bo0, d0} !== want0) begin
                bad++; $display("FAIL sweep_exact a=%h b=%h bin=%b got=%b_%h want=%b_%h", a, b, bin, bo0, d0, want0[8], want0[7:0]);
            end
            total++; if ({bo3, d3} !== want3) begin
                bad++; $display("FAIL sweep_approx a=%h b=%h bin=%b got=%b_%h want=%b_%h", a, b, bin, bo3, d3, want3[8], want3[7:0]);
            end
            total++; if (lat !== 8) begin bad++; $display("FAIL sweep_latency got=%0d want=8", lat); end
        end
    endtask

    initial begin
        test_reset();
        test_exact_basic();
        test_approx_error();
        test_borrow_kill();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
